axi_lite_arbiter: RTL

//  Shares the single AXI-lite slave port of the AXI->APB bridge between NUM_M AXI-lite masters (CPU, DMA, debug).

---
 rtl/axi_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/axi_lite_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI-lite master arbiter in front of the AXI->APB bridge.
package axi_arb_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      GRANT_WR = 3'd1,
      WAIT_B   = 3'd2,
      GRANT_RD = 3'd3,
      WAIT_R   = 3'd4
   } arb_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Index reached by stepping 'off' places past 'base' around a ring of n entries.
   function automatic int rr_idx(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
   import axi_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int GW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] ptr,
   output logic [N-1:0]  gnt_oh,
   output logic [GW-1:0] gnt_idx,
   output logic          gnt_any
);

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!gnt_any && req[rr_idx(int'(ptr), k, N)]) begin
            gnt_any = 1'b1;
            gnt_idx = GW'(rr_idx(int'(ptr), k, N));
            gnt_oh[rr_idx(int'(ptr), k, N)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Round-robin share of the bridge's AXI-lite slave port; one transaction in flight,
// grant held until the B or R handshake completes.
module axi_lite_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_M  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int GW     = $clog2(NUM_M)
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic [NUM_M-1:0]          m_awvalid,
   input  logic [NUM_M*ADDR_W-1:0]   m_awaddr,
   output logic [NUM_M-1:0]          m_awready,
   input  logic [NUM_M-1:0]          m_wvalid,
   input  logic [NUM_M*DATA_W-1:0]   m_wdata,
   output logic [NUM_M-1:0]          m_wready,
   output logic [NUM_M-1:0]          m_bvalid,
   output logic [1:0]                m_bresp,
   input  logic [NUM_M-1:0]          m_bready,
   input  logic [NUM_M-1:0]          m_arvalid,
   input  logic [NUM_M*ADDR_W-1:0]   m_araddr,
   output logic [NUM_M-1:0]          m_arready,
   output logic [NUM_M-1:0]          m_rvalid,
   output logic [DATA_W-1:0]         m_rdata,
   output logic [1:0]                m_rresp,
   input  logic [NUM_M-1:0]          m_rready,
   output logic                      s_awvalid,
   output logic [ADDR_W-1:0]         s_awaddr,
   input  logic                      s_awready,
   output logic                      s_wvalid,
   output logic [DATA_W-1:0]         s_wdata,
   input  logic                      s_wready,
   input  logic                      s_bvalid,
   input  logic [1:0]                s_bresp,
   output logic                      s_bready,
   output logic                      s_arvalid,
   output logic [ADDR_W-1:0]         s_araddr,
   input  logic                      s_arready,
   input  logic                      s_rvalid,
   input  logic [DATA_W-1:0]         s_rdata,
   input  logic [1:0]                s_rresp,
   output logic                      s_rready,
   output logic [GW-1:0]             o_grant_id,
   output logic                      o_busy
);

   arb_state_t          state_q, state_d;
   logic [GW-1:0]       gnt_q, ptr_q, ptr_next;
   logic                aw_done, w_done;
   logic [NUM_M-1:0]    arb_oh;
   logic [GW-1:0]       arb_idx;
   logic                arb_any;
   logic                aw_fin, w_fin, resp_hs;
   logic [ADDR_W-1:0]   awaddr_a [NUM_M];
   logic [ADDR_W-1:0]   araddr_a [NUM_M];
   logic [DATA_W-1:0]   wdata_a  [NUM_M];

   for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
      assign awaddr_a[i] = m_awaddr[i*ADDR_W +: ADDR_W];
      assign araddr_a[i] = m_araddr[i*ADDR_W +: ADDR_W];
      assign wdata_a[i]  = m_wdata[i*DATA_W +: DATA_W];
   end

   rr_arbiter #(.N(NUM_M), .GW(GW)) u_rr (
      .req     (m_awvalid | m_arvalid),
      .ptr     (ptr_q),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   // Address/data muxes are free-running; only the valids are gated by state.
   assign s_awaddr   = awaddr_a[gnt_q];
   assign s_araddr   = araddr_a[gnt_q];
   assign s_wdata    = wdata_a[gnt_q];
   assign m_bresp    = s_bresp;
   assign m_rdata    = s_rdata;
   assign m_rresp    = s_rresp;
   assign o_grant_id = gnt_q;
   assign o_busy     = (state_q != IDLE);

   // AW and W may complete in either order or together; the flags remember which already did.
   assign aw_fin   = aw_done | (s_awvalid & s_awready);
   assign w_fin    = w_done  | (s_wvalid  & s_wready);
   assign resp_hs  = ((state_q == WAIT_B) && s_bvalid && m_bready[gnt_q]) ||
                     ((state_q == WAIT_R) && s_rvalid && m_rready[gnt_q]);
   assign ptr_next = (gnt_q == GW'(NUM_M-1)) ? '0 : gnt_q + 1'b1;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && arb_any) gnt_q <= arb_idx;
         if (resp_hs)                    ptr_q <= ptr_next;
         if (state_q == GRANT_WR && !(aw_fin && w_fin)) begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
         end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (arb_any) state_d = (|(m_awvalid & arb_oh)) ? GRANT_WR : GRANT_RD;
         GRANT_WR: if (aw_fin && w_fin) state_d = WAIT_B;
         WAIT_B:   if (resp_hs) state_d = IDLE;
         GRANT_RD: if (s_arvalid && s_arready) state_d = WAIT_R;
         WAIT_R:   if (resp_hs) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      m_arready = '0;
      m_rvalid  = '0;
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      s_arvalid = 1'b0;
      s_bready  = 1'b0;
      s_rready  = 1'b0;
      case (state_q)
         GRANT_WR: begin
            s_awvalid        = m_awvalid[gnt_q] & ~aw_done;
            s_wvalid         = m_wvalid[gnt_q]  & ~w_done;
            m_awready[gnt_q] = s_awready & ~aw_done;
            m_wready[gnt_q]  = s_wready  & ~w_done;
         end
         WAIT_B: begin
            m_bvalid[gnt_q] = s_bvalid;
            s_bready        = m_bready[gnt_q];
         end
         GRANT_RD: begin
            s_arvalid        = m_arvalid[gnt_q];
            m_arready[gnt_q] = s_arready;
         end
         WAIT_R: begin
            m_rvalid[gnt_q] = s_rvalid;
            s_rready        = m_rready[gnt_q];
         end
         default: ;
      endcase
   end

endmodule
